// File: rtl/event_timestamper_pkg.sv
// event_timestamper_pkg
// Shared types and constants for the event timestamper.
//   ts_entry_t        : one queued timestamp {channel, seconds, micro}
//   SECONDS_WIDTH     : width of the seconds field
//   MICRO_WIDTH       : width of the microseconds field
//   channel_width()   : channel index width for a given event count (min 1)
package event_timestamper_pkg;

  localparam int SECONDS_WIDTH = 32;
  localparam int MICRO_WIDTH   = 32;

  // Channel field sized for the largest supported event count (16), so the
  // entry layout does not depend on the top-level parameter.
  localparam int CHANNEL_FIELD_WIDTH = 4;

  typedef struct packed {
    logic [CHANNEL_FIELD_WIDTH-1:0] channel;
    logic [SECONDS_WIDTH-1:0]       seconds;
    logic [MICRO_WIDTH-1:0]         micro;
  } ts_entry_t;

  localparam int ENTRY_WIDTH = $bits(ts_entry_t);

  function automatic int channel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/timestamp_fifo.sv
// timestamp_fifo
// Synchronous show-ahead FIFO: rd_data always shows the head entry.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   wr_en      : push wr_data (ignored when full, even with a read)
//   rd_en      : pop head (ignored when empty)
//   rd_data    : head entry (undefined contents while empty)
//   count      : occupied entries, 0..2**DEPTH_LOG2
//   full/empty : occupancy flags
// Handshake: a push happens on a cycle with wr_en=1 and full=0; a pop
// happens on a cycle with rd_en=1 and empty=0. Both may occur together.
module timestamp_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_wr, do_rd;

  assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(do_wr);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(do_rd);
    count_d  = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/event_timestamper.sv
// event_timestamper
// Timestamps rising edges on EVENT_COUNT synchronous event inputs with the
// upstream seconds/microseconds counters and queues them in a show-ahead FIFO.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   microsecondsSinceBoot, secondsSinceBoot, PPS : time inputs
//   events                            : event levels, rising edge = event
//   readStrobe                        : pop head when timestampValid=1
//   timestampValid/Channel/Seconds/Microseconds : head entry (zero when empty)
//   fifoCount                         : occupied entries
//   overflow, clearOverflow           : sticky loss flag and its clear
// Build option: EVENT_TIMESTAMPER_PPS_ALIGN_EN makes the microsecond field
// the offset from the last PPS instead of the raw microsecond count.
module event_timestamper
  import event_timestamper_pkg::*;
#(
  parameter int EVENT_COUNT     = 4,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [MICRO_WIDTH-1:0]               microsecondsSinceBoot,
  input  logic [SECONDS_WIDTH-1:0]             secondsSinceBoot,
  input  logic                                 PPS,
  input  logic [EVENT_COUNT-1:0]               events,
  input  logic                                 readStrobe,
  output logic                                 timestampValid,
  output logic [channel_width(EVENT_COUNT)-1:0] timestampChannel,
  output logic [SECONDS_WIDTH-1:0]             timestampSeconds,
  output logic [MICRO_WIDTH-1:0]               timestampMicroseconds,
  output logic [FIFO_DEPTH_LOG2:0]             fifoCount,
  output logic                                 overflow,
  input  logic                                 clearOverflow
);

  localparam int CW = channel_width(EVENT_COUNT);
  localparam int TW = SECONDS_WIDTH + MICRO_WIDTH;

  logic [EVENT_COUNT-1:0] events_prev_q, events_prev_d, edges;
  logic [EVENT_COUNT-1:0] pending_q, pending_d;
  logic [TW-1:0]          cap_q [EVENT_COUNT];
  logic [TW-1:0]          cap_d [EVENT_COUNT];
  logic                   overflow_q, overflow_d;
  logic                   lost;
  logic [MICRO_WIDTH-1:0] micro;
  logic [TW-1:0]          now;
  logic [CW-1:0]          wr_sel;
  logic                   wr_en;
  ts_entry_t              wr_entry, head;
  logic [ENTRY_WIDTH-1:0] head_bits;
  logic                   fifo_full, fifo_empty;
  logic                   unused_chan_bits;

`ifdef EVENT_TIMESTAMPER_PPS_ALIGN_EN
  logic [MICRO_WIDTH-1:0] usec_at_pps_q, usec_at_pps_d;

  // Using the next base value makes an edge in the PPS cycle read as 0.
  assign usec_at_pps_d = PPS ? microsecondsSinceBoot : usec_at_pps_q;
  assign micro         = microsecondsSinceBoot - usec_at_pps_d;

  always_ff @(posedge clk) begin
    if (reset) usec_at_pps_q <= '0;
    else       usec_at_pps_q <= usec_at_pps_d;
  end
`else
  logic unused_pps;
  assign unused_pps = PPS;
  assign micro      = microsecondsSinceBoot;
`endif

  assign now           = {secondsSinceBoot, micro};
  assign events_prev_d = events;
  assign edges         = events & ~events_prev_q;

  always_comb begin
    // Lowest pending index wins the single write slot.
    wr_sel = '0;
    for (int i = EVENT_COUNT - 1; i >= 0; i--) begin
      if (pending_q[i]) wr_sel = CW'(i);
    end
    wr_en = (|pending_q) && !fifo_full;
    wr_entry.channel = CHANNEL_FIELD_WIDTH'(wr_sel);
    {wr_entry.seconds, wr_entry.micro} = cap_q[wr_sel];

    pending_d = pending_q;
    cap_d     = cap_q;
    lost      = 1'b0;
    for (int i = 0; i < EVENT_COUNT; i++) begin
      if (edges[i]) begin
        // A channel draining this cycle frees its register for the new edge.
        if (!pending_q[i] || (wr_en && wr_sel == CW'(i))) begin
          pending_d[i] = 1'b1;
          cap_d[i]     = now;
        end else begin
          lost = 1'b1;
        end
      end else if (wr_en && wr_sel == CW'(i)) begin
        pending_d[i] = 1'b0;
      end
    end

    // A loss wins over a simultaneous clear.
    overflow_d = lost ? 1'b1 : (clearOverflow ? 1'b0 : overflow_q);
  end

  // Edge history keeps tracking through reset so a level held across
  // release is not mistaken for an event.
  always_ff @(posedge clk) begin
    events_prev_q <= events_prev_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < EVENT_COUNT; i++) cap_q[i] <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < EVENT_COUNT; i++) cap_q[i] <= cap_d[i];
    end
  end

  timestamp_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (ENTRY_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (readStrobe),
    .rd_data (head_bits),
    .count   (fifoCount),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head             = ts_entry_t'(head_bits);
  assign unused_chan_bits = ^head.channel;

  // Storage is unreset, so the head is forced to zero while empty.
  assign timestampValid        = !fifo_empty;
  assign timestampChannel      = fifo_empty ? '0 : head.channel[CW-1:0];
  assign timestampSeconds      = fifo_empty ? '0 : head.seconds;
  assign timestampMicroseconds = fifo_empty ? '0 : head.micro;
  assign overflow              = overflow_q;

endmodule

// File: tb/tb_event_timestamper.sv
module tb_event_timestamper;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] microsecondsSinceBoot = '0;
  logic [31:0] secondsSinceBoot = '0;
  logic        PPS = 1'b0;
  logic [3:0]  events = '0;
  logic        readStrobe = 1'b0;
  logic        timestampValid;
  logic [1:0]  timestampChannel;
  logic [31:0] timestampSeconds;
  logic [31:0] timestampMicroseconds;
  logic [4:0]  fifoCount;
  logic        overflow;
  logic        clearOverflow = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [65:0] exp_q[$];

  event_timestamper dut (
    .clk                   (clk),
    .reset                 (reset),
    .microsecondsSinceBoot (microsecondsSinceBoot),
    .secondsSinceBoot      (secondsSinceBoot),
    .PPS                   (PPS),
    .events                (events),
    .readStrobe            (readStrobe),
    .timestampValid        (timestampValid),
    .timestampChannel      (timestampChannel),
    .timestampSeconds      (timestampSeconds),
    .timestampMicroseconds (timestampMicroseconds),
    .fifoCount             (fifoCount),
    .overflow              (overflow),
    .clearOverflow         (clearOverflow)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_time(input logic [31:0] sec, input logic [31:0] usec);
    secondsSinceBoot      = sec;
    microsecondsSinceBoot = usec;
  endtask

  // Holds mask high for one cycle; returns in the cycle after the edge.
  task automatic drive_edge(input logic [3:0] mask, input bit push, input logic [31:0] exp_micro);
    events = mask;
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) exp_q.push_back({2'(i), secondsSinceBoot, exp_micro});
      end
    end
    step();
    events = '0;
  endtask

  // Scoreboard: wait (bounded) for a head entry, compare, then pop it.
  task automatic read_check(input string tag);
    logic [65:0] exp_e;
    int waited;
    waited = 0;
    while (!timestampValid && waited < 20) begin
      step();
      waited++;
    end
    check({tag, "_valid"}, timestampValid, 1'b1);
    if (timestampValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_extra: observed unexpected entry %0h expected none", tag,
               {timestampChannel, timestampSeconds, timestampMicroseconds});
      end else begin
        exp_e = exp_q.pop_front();
        check(tag, {timestampChannel, timestampSeconds, timestampMicroseconds}, exp_e);
      end
      readStrobe = 1'b1;
      step();
      readStrobe = 1'b0;
    end
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("rst_valid", timestampValid, 1'b0);
    check("rst_count", fifoCount, 5'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_channel", timestampChannel, 2'd0);
    check("rst_seconds", timestampSeconds, 32'd0);
    check("rst_micro", timestampMicroseconds, 32'd0);
    step();

    // single event on ch2: visible two cycles after the edge
    set_time(32'd5, 32'd123);
    drive_edge(4'b0100, 1'b1, 32'd123);
    check("single_n1_valid", timestampValid, 1'b0);
    step();
    check("single_n2_valid", timestampValid, 1'b1);
    check("single_count", fifoCount, 5'd1);
    read_check("single_entry");
    check("single_post_valid", timestampValid, 1'b0);
    check("single_post_count", fifoCount, 5'd0);

    // simultaneous edges on ch0 and ch3
    set_time(32'd7, 32'd40);
    drive_edge(4'b1001, 1'b1, 32'd40);
    step();
    check("simul_n2_channel", timestampChannel, 2'd0);
    check("simul_n2_count", fifoCount, 5'd1);
    step();
    check("simul_n3_count", fifoCount, 5'd2);
    read_check("simul_first");
    read_check("simul_second");

    // fill the FIFO with 16 entries
    for (int k = 0; k < 16; k++) begin
      set_time(32'(100 + k), 32'(10 * k));
      drive_edge(4'(1 << (k % 4)), 1'b1, 32'(10 * k));
      step();
    end
    step();
    check("full_count", fifoCount, 5'd16);

    // 17th edge on ch1 must wait as pending
    set_time(32'd200, 32'd777);
    drive_edge(4'b0010, 1'b1, 32'd777);
    repeat (3) step();
    check("full_count_held", fifoCount, 5'd16);
    check("full_pending1", dut.pending_q[1], 1'b1);
    check("full_no_overflow", overflow, 1'b0);
    read_check("full_head");
    check("full_after_read_count", fifoCount, 5'd15);
    step();
    check("full_refill_count", fifoCount, 5'd16);
    check("full_pending1_clear", dut.pending_q[1], 1'b0);
    check("full_overflow_still0", overflow, 1'b0);

    // loss: two edges on ch1 while full
    set_time(32'd300, 32'd1);
    drive_edge(4'b0010, 1'b1, 32'd1);
    step();
    set_time(32'd301, 32'd2);
    drive_edge(4'b0010, 1'b0, 32'd0);
    check("loss_overflow", overflow, 1'b1);
    step();
    events = 4'b0010;
    clearOverflow = 1'b1;
    step();
    events = '0;
    clearOverflow = 1'b0;
    check("loss_set_beats_clear", overflow, 1'b1);
    step();
    clearOverflow = 1'b1;
    step();
    clearOverflow = 1'b0;
    check("loss_cleared", overflow, 1'b0);
    for (int k = 0; k < 17; k++) read_check("drain");
    step();
    check("drain_valid", timestampValid, 1'b0);
    check("drain_count", fifoCount, 5'd0);

    // PPS alignment
    set_time(32'd10, 32'd2000000);
    PPS = 1'b1;
    step();
    PPS = 1'b0;
    set_time(32'd10, 32'd2000250);
`ifdef EVENT_TIMESTAMPER_PPS_ALIGN_EN
    drive_edge(4'b0001, 1'b1, 32'd250);
`else
    drive_edge(4'b0001, 1'b1, 32'd2000250);
`endif
    step();
    set_time(32'd11, 32'd3000000);
    PPS = 1'b1;
`ifdef EVENT_TIMESTAMPER_PPS_ALIGN_EN
    drive_edge(4'b0100, 1'b1, 32'd0);
`else
    drive_edge(4'b0100, 1'b1, 32'd3000000);
`endif
    PPS = 1'b0;
    read_check("pps_offset");
    read_check("pps_same_cycle");

    // reset with queued entries and ch0 held high through release
    set_time(32'd20, 32'd30);
    drive_edge(4'b0010, 1'b0, 32'd0);
    step();
    drive_edge(4'b0100, 1'b0, 32'd0);
    step();
    drive_edge(4'b1000, 1'b0, 32'd0);
    repeat (3) step();
    check("rst2_queued_count", fifoCount, 5'd3);
    events = 4'b0001;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (4) step();
    check("rst2_count", fifoCount, 5'd0);
    check("rst2_valid", timestampValid, 1'b0);
    check("rst2_pending", dut.pending_q, 4'b0000);
    events = '0;
    step();
    set_time(32'd50, 32'd60);
    drive_edge(4'b1000, 1'b1, 32'd60);
    step();
    read_check("rst2_after");
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
